block_drop_controller: RTL and testbench

- Upstream stage of the overlap detector in the stacking game.
- Sweeps the active block left and right across the play field and latches its x position when the player drops it.
- Holds the x position of the previous (committed) row and presents the curr/prev pair to the overlap detector.
- Samples the detector verdict, then either commits the row and advances, or ends the game.

---
 rtl/block_drop_controller_pkg.sv | 22 ++
 rtl/block_drop_controller_rise.sv | 26 ++
 rtl/block_drop_controller.sv | 132 +++++++++++++
 tb/tb_block_drop_controller.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/block_drop_controller_pkg.sv
`default_nettype none
// ============================================================================
// block_drop_controller_pkg : shared stacking-game geometry and controller states
// Revision : 1.0
// ============================================================================
package block_drop_controller_pkg;

   localparam int FIELD_W = 160;
   localparam int BLOCK_W = 10;
   localparam logic [7:0] XMAX   = 8'(FIELD_W - BLOCK_W);
   localparam logic [7:0] BASE_X = 8'd75;

   typedef enum logic [2:0] {
      MOVE      = 3'd0,
      WAIT      = 3'd1,
      DECIDE    = 3'd2,
      GAME_OVER = 3'd3,
      WIN       = 3'd4
   } state_e;

endpackage
`default_nettype wire

// File: rtl/block_drop_controller_rise.sv
`default_nettype none
// ============================================================================
// rise_edge_detect : registers a level and flags the cycle it goes 0 -> 1
// Revision : 1.0
// ============================================================================
module rise_edge_detect (
   input  logic clk,
   input  logic resetn,
   input  logic d_i,
   output logic rise_o
);

   logic d_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         d_q <= 1'b0;
      end else begin
         d_q <= d_i;
      end
   end

   assign rise_o = d_i & ~d_q;

endmodule
`default_nettype wire

// File: rtl/block_drop_controller.sv
`default_nettype none
// ============================================================================
// block_drop_controller : sweeps the active block, latches drops, commits rows
// Revision : 1.0
// ============================================================================
module block_drop_controller
   import block_drop_controller_pkg::*;
#(
   parameter int TICK_DIV = 833334,
   parameter int MAX_ROWS = 12
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       drop,
   input  logic       restart,
   input  logic       overlap_q,
   output logic [7:0] moving_x,
   output logic [7:0] curr_x_position,
   output logic [7:0] prev_x_position,
   output logic [3:0] row,
   output logic       commit,
   output logic       game_over,
   output logic       win
);

   localparam int CNT_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [3:0]       ROW_WIN   = 4'(MAX_ROWS);

   state_e           state_q, state_d;
   logic [7:0]       x_q, x_d;
   logic             right_q, right_d;
   logic [7:0]       curr_q, curr_d;
   logic [7:0]       prev_q, prev_d;
   logic [3:0]       row_q, row_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             drop_rise;

   rise_edge_detect u_drop_edge (
      .clk    (clk),
      .resetn (resetn),
      .d_i    (drop),
      .rise_o (drop_rise)
   );

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      right_d = right_q;
      curr_d  = curr_q;
      prev_d  = prev_q;
      row_d   = row_q;
      cnt_d   = cnt_q;

      case (state_q)
         MOVE: begin
            // A drop in the same cycle as a tick wins: latch the pre-tick x.
            if (drop_rise) begin
               curr_d  = x_q;
               state_d = WAIT;
            end else if (cnt_q == TICK_LAST) begin
               cnt_d = '0;
               if (right_q) begin
                  if (x_q == XMAX) right_d = 1'b0;
                  else             x_d     = x_q + 8'd1;
               end else begin
                  if (x_q == 8'd0) right_d = 1'b1;
                  else             x_d     = x_q - 8'd1;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WAIT: begin
            state_d = DECIDE;
         end
         DECIDE: begin
            if (overlap_q) begin
               prev_d  = curr_q;
               row_d   = row_q + 4'd1;
               state_d = (row_q + 4'd1 == ROW_WIN) ? WIN : MOVE;
            end else begin
               state_d = GAME_OVER;
            end
         end
         GAME_OVER, WIN: begin
            if (restart) begin
               state_d = MOVE;
               x_d     = 8'd0;
               right_d = 1'b1;
               curr_d  = BASE_X;
               prev_d  = BASE_X;
               row_d   = 4'd0;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = MOVE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= MOVE;
         x_q     <= 8'd0;
         right_q <= 1'b1;
         curr_q  <= BASE_X;
         prev_q  <= BASE_X;
         row_q   <= 4'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         right_q <= right_d;
         curr_q  <= curr_d;
         prev_q  <= prev_d;
         row_q   <= row_d;
         cnt_q   <= cnt_d;
      end
   end

   assign moving_x        = x_q;
   assign curr_x_position = curr_q;
   assign prev_x_position = prev_q;
   assign row             = row_q;
   assign commit          = (state_q == DECIDE) && overlap_q;
   assign game_over       = (state_q == GAME_OVER);
   assign win             = (state_q == WIN);

endmodule
`default_nettype wire

// File: tb/tb_block_drop_controller.sv
`default_nettype none
// ============================================================================
// tb_block_drop_controller : directed bench, TICK_DIV=2 and MAX_ROWS=3
// Revision : 1.0
// ============================================================================
module tb_block_drop_controller;

   logic       clk = 1'b0;
   logic       resetn, drop, restart, overlap_q;
   logic [7:0] moving_x, curr_x_position, prev_x_position;
   logic [3:0] row;
   logic       commit, game_over, win;

   int n_chk = 0;
   int n_bad = 0;

   block_drop_controller #(.TICK_DIV(2), .MAX_ROWS(3)) dut (
      .clk             (clk),
      .resetn          (resetn),
      .drop            (drop),
      .restart         (restart),
      .overlap_q       (overlap_q),
      .moving_x        (moving_x),
      .curr_x_position (curr_x_position),
      .prev_x_position (prev_x_position),
      .row             (row),
      .commit          (commit),
      .game_over       (game_over),
      .win             (win)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Returns just after the edge on which moving_x reaches target.
   task automatic wait_x(input int target, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (moving_x == 8'(target)) break;
         tick(1);
      end
      chk("reach_x", moving_x, target);
   endtask

   task automatic drop_key(input logic ov, output logic cm);
      drop = 1'b0;
      tick(1);
      drop = 1'b1;
      tick(1);
      drop = 1'b0;
      overlap_q = ov;
      tick(1);
      cm = commit;
      tick(1);
      overlap_q = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_x"},    moving_x, 0);
      chk({tag, "_curr"}, curr_x_position, 75);
      chk({tag, "_prev"}, prev_x_position, 75);
      chk({tag, "_row"},  row, 0);
      chk({tag, "_cm"},   commit, 0);
      chk({tag, "_go"},   game_over, 0);
      chk({tag, "_win"},  win, 0);
   endtask

   initial begin
      logic cm;
      int   maxx;
      int   ncm;
      logic [7:0] xs;

      resetn = 1'b0; drop = 1'b0; restart = 1'b0; overlap_q = 1'b0;
      tick(3);
      resetn = 1'b1;
      chk_reset_vals("rst");

      // Sweep: x advances every 2 edges, holds one tick at each wall.
      maxx = 0;
      for (int k = 1; k <= 606; k++) begin
         tick(1);
         if (moving_x > maxx) maxx = moving_x;
         if (k == 2)   chk("sweep_k2",   moving_x, 1);
         if (k == 300) chk("sweep_k300", moving_x, 150);
         if (k == 302) chk("sweep_k302", moving_x, 150);
         if (k == 304) chk("sweep_k304", moving_x, 149);
         if (k == 602) chk("sweep_k602", moving_x, 0);
         if (k == 604) chk("sweep_k604", moving_x, 0);
         if (k == 606) chk("sweep_k606", moving_x, 1);
      end
      chk("sweep_max", maxx, 150);

      // Hit at x=80.
      wait_x(80, 400);
      tick(1);
      drop = 1'b1;
      tick(1);
      drop = 1'b0;
      overlap_q = 1'b1;
      chk("hit_curr", curr_x_position, 80);
      chk("hit_cm_wait", commit, 0);
      tick(1);
      chk("hit_cm_decide", commit, 1);
      tick(1);
      overlap_q = 1'b0;
      chk("hit_cm_after", commit, 0);
      chk("hit_prev", prev_x_position, 80);
      chk("hit_row", row, 1);
      chk("hit_x_kept", moving_x, 80);
      chk("hit_go", game_over, 0);

      // Held key, drop landing on a tick-wrap cycle at x=40 (descending).
      wait_x(40, 1000);
      tick(1);
      drop = 1'b1;
      overlap_q = 1'b1;
      ncm = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (commit) ncm++;
      end
      drop = 1'b0;
      overlap_q = 1'b0;
      chk("held_commits", ncm, 1);
      chk("held_curr", curr_x_position, 40);
      chk("held_prev", prev_x_position, 40);
      chk("held_row", row, 2);

      // Third accepted row wins.
      drop_key(1'b1, cm);
      chk("win_cm", cm, 1);
      chk("win_flag", win, 1);
      chk("win_row", row, 3);
      xs = moving_x;
      tick(4);
      chk("win_frozen_x", moving_x, xs);
      drop_key(1'b1, cm);
      chk("win_drop_ign", cm, 0);
      chk("win_row_kept", row, 3);
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
      chk_reset_vals("win_rst");

      // Miss at x=100 against prev=75.
      wait_x(100, 400);
      drop_key(1'b0, cm);
      chk("miss_cm", cm, 0);
      chk("miss_go", game_over, 1);
      chk("miss_row", row, 0);
      chk("miss_curr", curr_x_position, 100);
      chk("miss_prev", prev_x_position, 75);
      drop_key(1'b1, cm);
      chk("go_drop_cm", cm, 0);
      chk("go_drop_row", row, 0);
      chk("go_drop_curr", curr_x_position, 100);
      chk("go_still", game_over, 1);
      restart = 1'b1;
      tick(1);
      restart = 1'b0;
      chk_reset_vals("go_rst");
      tick(2);
      chk("go_rst_moving", moving_x, 1);

      // Reset asserted during WAIT.
      wait_x(5, 100);
      drop = 1'b1;
      tick(1);
      chk("rw_curr_latched", curr_x_position, 5);
      resetn = 1'b0;
      drop = 1'b0;
      overlap_q = 1'b1;
      tick(1);
      chk_reset_vals("rw");
      resetn = 1'b1;
      overlap_q = 1'b0;
      tick(2);
      chk("rw_moving", moving_x, 1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
